// File: rtl/l1c_arb_pkg.sv
// l1c_arb_pkg: shared types and constants for the L1 memory-port arbiter.
// State encoding, owner encoding and default line-fill length.
package l1c_arb_pkg;

  localparam int L1C_BURST_LEN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/l1c_arb_rr.sv
// l1c_arb_rr: combinational 2-way round-robin picker.
// On a conflict the requester that was not served last wins.
module l1c_arb_rr
  import l1c_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (1'b1)
      (&req):  grant = (last == OWN_D) ? 2'b01 : 2'b10;
      default: grant = req;
    endcase
  end

endmodule

// File: rtl/l1c_mem_arbiter.sv
// l1c_mem_arbiter: shares one downstream memory port between the
// I-cache and D-cache; each transaction keeps the grant until done.
module l1c_mem_arbiter
  import l1c_arb_pkg::*;
#(
  parameter int BURST_LEN = L1C_BURST_LEN,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_write,
  input  logic [31:0]       i_in,
  input  logic [2:0]        i_type,
  output logic [31:0]       i_out,
  output logic              i_wait,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_write,
  input  logic [31:0]       d_in,
  input  logic [2:0]        d_type,
  output logic [31:0]       d_out,
  output logic              d_wait,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_write,
  output logic [31:0]       m_in,
  output logic [2:0]        m_type,
  input  logic [31:0]       m_out,
  input  logic              m_wait
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             last, last_nxt;

  logic [1:0] grant;
  logic       own_req;
  logic       own_write;
  logic       beat;
  logic       done;

  l1c_arb_rr u_rr (
    .req   ({d_req, i_req}),
    .last  (last),
    .grant (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      last     <= OWN_D;
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      last     <= last_nxt;
    end
  end

  // Owner's request/write are read live; the owner keeps them stable.
  always_comb begin
    own_req   = 1'b0;
    own_write = 1'b0;
    unique case (state)
      GNT_I: begin
        own_req   = i_req;
        own_write = i_write;
      end
      GNT_D: begin
        own_req   = d_req;
        own_write = d_write;
      end
      default: ;
    endcase
    beat = own_req && !m_wait;
    done = beat && (own_write || beat_cnt == CNT_LAST);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (grant[OWN_I]) begin
          state_nxt = GNT_I;
        end else if (grant[OWN_D]) begin
          state_nxt = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        if (!own_req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          last_nxt  = (state == GNT_D) ? OWN_D : OWN_I;
        end else if (beat) begin
          cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    m_req   = 1'b0;
    m_addr  = '0;
    m_write = 1'b0;
    m_in    = '0;
    m_type  = '0;
    i_out   = '0;
    i_wait  = 1'b1;
    d_out   = '0;
    d_wait  = 1'b1;
    unique case (state)
      GNT_I: begin
        m_req   = i_req;
        m_addr  = i_addr;
        m_write = i_write;
        m_in    = i_in;
        m_type  = i_type;
        i_out   = m_out;
        i_wait  = m_wait;
      end
      GNT_D: begin
        m_req   = d_req;
        m_addr  = d_addr;
        m_write = d_write;
        m_in    = d_in;
        m_type  = d_type;
        d_out   = m_out;
        d_wait  = m_wait;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// tb_l1c_mem_arbiter: directed scenarios plus randomized traffic
// checked by per-requester beat scoreboards and a round-robin model.
module tb_l1c_mem_arbiter;
  import l1c_arb_pkg::*;

  localparam int BL = 4;
  localparam logic [2:0] CACHE_BYTE  = 3'd0;
  localparam logic [2:0] CACHE_HWORD = 3'd1;
  localparam logic [2:0] CACHE_WORD  = 3'd2;

  logic        clk, rst;
  logic        i_req, i_write, d_req, d_write;
  logic [31:0] i_addr, d_addr, i_in, d_in;
  logic [2:0]  i_type, d_type;
  logic [31:0] i_out, d_out;
  logic        i_wait, d_wait;
  logic        m_req, m_write, m_wait;
  logic [31:0] m_addr, m_in, m_out;
  logic [2:0]  m_type;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [2:0]  ty;
    bit          lst;
  } exp_t;

  exp_t q_i[$];
  exp_t q_d[$];

  bit rnd_on = 0;
  bit bubble_due = 0;
  bit arb_due = 0;
  bit arb_exp = 0;
  bit last_m = 1;
  int ndone = 0;

  l1c_mem_arbiter #(.BURST_LEN(BL), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_write(i_write),
    .i_in(i_in), .i_type(i_type), .i_out(i_out), .i_wait(i_wait),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write),
    .d_in(d_in), .d_type(d_type), .d_out(d_out), .d_wait(d_wait),
    .m_req(m_req), .m_addr(m_addr), .m_write(m_write),
    .m_in(m_in), .m_type(m_type), .m_out(m_out), .m_wait(m_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    i_req = 0; i_write = 0; i_addr = 0; i_in = 0; i_type = CACHE_WORD;
    d_req = 0; d_write = 0; d_addr = 0; d_in = 0; d_type = CACHE_WORD;
    m_wait = 0; m_out = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_all();
    step();
    step();
    rst = 0;
  endtask

  // n beats with m_wait low; checks the owner sees each beat.
  task automatic burst(input bit is_d, input logic [31:0] addr,
                       input logic [31:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      m_out = base + b;
      @(negedge clk);
      chk("b_mreq", m_req, 1);
      chk("b_maddr", m_addr, addr);
      if (is_d) begin
        chk("b_dwait", d_wait, 0);
        chk("b_dout", d_out, base + b);
        chk("b_iwait", i_wait, 1);
      end else begin
        chk("b_iwait", i_wait, 0);
        chk("b_iout", i_out, base + b);
        chk("b_dwait", d_wait, 1);
      end
      step();
    end
  endtask

  task automatic run_req(input bit is_d, input int n);
    for (int t = 0; t < n; t++) begin
      logic [31:0] a;
      logic        w;
      logic [31:0] dat;
      logic [2:0]  ty;
      int nb, got, cyc, gap;
      a   = (is_d ? 32'h2000_0000 : 32'h1000_0000) | ($urandom & 32'hFFFC);
      w   = ($urandom_range(0, 3) == 0);
      dat = $urandom;
      ty  = 3'($urandom_range(0, 2));
      nb  = w ? 1 : BL;
      for (int b = 0; b < nb; b++) begin
        if (is_d) q_d.push_back('{a, w, dat, ty, b == nb - 1});
        else      q_i.push_back('{a, w, dat, ty, b == nb - 1});
      end
      if (is_d) begin
        d_req = 1; d_addr = a; d_write = w; d_in = dat; d_type = ty;
      end else begin
        i_req = 1; i_addr = a; i_write = w; i_in = dat; i_type = ty;
      end
      got = 0;
      cyc = 0;
      while (got < nb && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if ((is_d ? d_wait : i_wait) == 1'b0) got++;
      end
      chk(is_d ? "d_txn_done" : "i_txn_done", got, nb);
      step();
      if (is_d) d_req = 0;
      else      i_req = 0;
      gap = $urandom_range(0, 2);
      repeat (gap) step();
    end
    ndone++;
  endtask

  task automatic mem_drv();
    while (ndone < 2) begin
      m_wait = ($urandom_range(0, 2) == 0);
      m_out  = $urandom;
      step();
    end
    m_wait = 0;
  endtask

  // Scoreboard monitor for the randomized phase.
  always @(negedge clk) begin
    if (rnd_on) begin
      exp_t e;
      bit   o, have;
      int   nz;
      nz = int'(i_wait == 1'b0) + int'(d_wait == 1'b0);
      chk("wait_onehot", nz, (m_req && !m_wait) ? 1 : 0);
      if (bubble_due) begin
        chk("bubble", m_req, 0);
        bubble_due = 0;
      end
      if (arb_due) begin
        chk("rr_mreq", m_req, 1);
        chk("rr_grant", m_addr[31:28], arb_exp ? 4'h2 : 4'h1);
        arb_due = 0;
      end
      if (m_req && !m_wait) begin
        o = (d_wait == 1'b0);
        have = o ? (q_d.size() > 0) : (q_i.size() > 0);
        chk("q_nonempty", have, 1);
        if (have) begin
          e = o ? q_d.pop_front() : q_i.pop_front();
          chk("m_addr", m_addr, e.a);
          chk("m_write", m_write, e.w);
          chk("m_type", m_type, e.ty);
          chk("m_in", m_in, e.d);
          chk("own_out", o ? d_out : i_out, m_out);
          chk("other_out", o ? i_out : d_out, 0);
          if (e.lst) begin
            bubble_due = 1;
            last_m = o;
          end
        end
      end
      if (!m_req && (i_req || d_req)) begin
        arb_due = 1;
        arb_exp = (i_req && d_req) ? !last_m : d_req;
      end
    end
  end

  initial begin
    // Reset state
    rst = 1;
    idle_all();
    #1;
    chk("rst_mreq", m_req, 0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_iwait", i_wait, 1);
    chk("rst_dwait", d_wait, 1);
    chk("rst_iout", i_out, 0);
    chk("rst_dout", d_out, 0);
    step();
    rst = 0;

    // Single I read line fill
    i_req = 1; i_addr = 32'h0000_1000; m_wait = 0;
    @(negedge clk);
    chk("t1_idle", m_req, 0);
    step();
    burst(0, 32'h0000_1000, 32'hA0, BL);
    i_req = 0;
    @(negedge clk);
    chk("t1_bubble", m_req, 0);
    chk("t1_last", dut.last, 0);
    step();

    // Simultaneous reads after reset: I first, then D
    do_reset();
    i_req = 1; i_addr = 32'h0000_1100;
    d_req = 1; d_addr = 32'h0000_2200;
    @(negedge clk);
    chk("t2_idle", m_req, 0);
    step();
    burst(0, 32'h0000_1100, 32'hB0, BL);
    i_req = 0;
    @(negedge clk);
    chk("t2_bubble", m_req, 0);
    chk("t2_dwait_bub", d_wait, 1);
    step();
    burst(1, 32'h0000_2200, 32'hC0, BL);
    d_req = 0;
    @(negedge clk);
    chk("t2_last", dut.last, 1);
    step();

    // D write with three wait cycles
    do_reset();
    d_req = 1; d_addr = 32'h0000_2004; d_write = 1;
    d_in = 32'hDEAD_BEEF; d_type = CACHE_BYTE; m_wait = 1;
    @(negedge clk);
    chk("t3_idle", m_req, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_mreq", m_req, 1);
      chk("t3_min", m_in, 32'hDEAD_BEEF);
      chk("t3_mtype", m_type, CACHE_BYTE);
      chk("t3_mwrite", m_write, 1);
      chk("t3_dwait_hold", d_wait, 1);
      step();
    end
    m_wait = 0;
    @(negedge clk);
    chk("t3_dwait_go", d_wait, 0);
    step();
    d_req = 0; d_write = 0;
    @(negedge clk);
    chk("t3_state", dut.state, IDLE);
    chk("t3_last", dut.last, 1);
    step();

    // Abort after two beats, then a normal I read
    do_reset();
    d_req = 1; d_addr = 32'h0000_2300;
    @(negedge clk);
    chk("t4_idle", m_req, 0);
    step();
    burst(1, 32'h0000_2300, 32'hD0, 2);
    d_req = 0;
    step();
    i_req = 1; i_addr = 32'h0000_1400;
    @(negedge clk);
    chk("t4_state", dut.state, IDLE);
    chk("t4_cnt", dut.beat_cnt, 0);
    chk("t4_last", dut.last, 1);
    chk("t4_mreq", m_req, 0);
    step();
    burst(0, 32'h0000_1400, 32'hE0, BL);
    i_req = 0;
    step();

    // Reset in the middle of a D burst
    do_reset();
    d_req = 1; d_addr = 32'h0000_2500;
    @(negedge clk);
    step();
    burst(1, 32'h0000_2500, 32'hF0, 2);
    rst = 1;
    #1;
    chk("t5_mreq", m_req, 0);
    chk("t5_maddr", m_addr, 0);
    chk("t5_dwait", d_wait, 1);
    chk("t5_dout", d_out, 0);
    chk("t5_state", dut.state, IDLE);
    chk("t5_cnt", dut.beat_cnt, 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("t5_idle", m_req, 0);
    step();
    burst(1, 32'h0000_2500, 32'h50, BL);
    d_req = 0;
    step();

    // Randomized traffic from both caches
    do_reset();
    last_m = 1;
    ndone = 0;
    rnd_on = 1;
    fork
      run_req(0, 40);
      run_req(1, 40);
      mem_drv();
    join
    step();
    step();
    rnd_on = 0;
    chk("q_drained", q_i.size() + q_d.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
